evenzeroes_tx: RTL and testbench

Clocked transmitter for the dual-rail four-phase even-zeroes link. It accepts single bits from a synchronous producer over a valid/ready handshake and drives them onto the `bit0`/`bit1` dual-rail pair. It then completes the four-phase return-to-zero handshake against the asynchronous receiver's `parity0`/`parity1` rails. It also keeps a reference model of the running zero-count parity and flags every disagreement with the receiver's answer, along with protocol violations and timeouts.

---
 rtl/evenzeroes_pkg.sv | 24 ++
 rtl/evenzeroes_tx_chk.sv | 15 +
 rtl/rail_sync.sv | 34 +++
 rtl/evenzeroes_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_evenzeroes_tx.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/evenzeroes_pkg.sv
// Shared types and constants for the even-zeroes dual-rail transmitter.
// Contents:
//   state_e          - handshake FSM states
//   RAIL_P0/RAIL_P1  - bit positions of the receiver rails in rail vectors
//   zeros_odd_next   - running zero-count parity update for one data bit
package evenzeroes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RTZ   = 2'd2,
        FAULT = 2'd3
    } state_e;

    localparam int RAIL_P0 = 0;
    localparam int RAIL_P1 = 1;
    localparam int RAIL_N  = 2;

    // A zero data bit flips the zero-count parity, a one leaves it alone.
    function automatic logic zeros_odd_next(input logic zeros_odd, input logic data_bit);
        return zeros_odd ^ ~data_bit;
    endfunction

endpackage

// File: rtl/evenzeroes_tx_chk.sv
// Property checker for the transmitter's data rails.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   bit0, bit1 - the dual-rail data pair driven by the transmitter
module evenzeroes_tx_chk (
    input logic clk,
    input logic rst,
    input logic bit0,
    input logic bit1
);

    // Both data rails high is not a legal codeword on the link.
    a_rails_exclusive: assert property (@(posedge clk) disable iff (rst) !(bit0 && bit1));

endmodule

// File: rtl/rail_sync.sv
// Multi-flop synchronizer for one asynchronous receiver rail.
// Ports:
//   clk - sampling clock
//   rst - synchronous active-high reset, clears the chain
//   d   - asynchronous rail input
//   q   - synchronized rail, SYNC_STAGES edges behind d
module rail_sync
    import evenzeroes_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Fewer than two flops gives no metastability settling time, so clamp.
    localparam int STAGES_C = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES_C-1:0] sync_r;

    // Shift the rail through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES_C-2:0], d};
        end
    end

    assign q = sync_r[STAGES_C-1];

endmodule

// File: rtl/evenzeroes_tx.sv
// Clocked transmitter for the dual-rail four-phase even-zeroes link.
// Accepts bits over valid/ready, drives them on bit0/bit1, completes the
// return-to-zero handshake against parity0/parity1 and compares each answer
// with a local model of the running zero-count parity.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_bit     - producer bit offer
//   in_ready            - block can accept a bit this cycle
//   bit0, bit1          - registered data rails
//   parity0, parity1    - asynchronous receiver rails (odd / even zeros)
//   res_valid           - one-cycle pulse carrying res_parity
//   res_parity          - 1 when the receiver reported even zeros
//   mismatch            - sticky, receiver disagreed with the model
//   proto_err           - sticky, illegal rail combination seen
//   timeout             - sticky, a handshake phase took too long
//   xfer_count          - completed four-phase transfers, wrapping
module evenzeroes_tx
    import evenzeroes_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             bit0,
    output logic             bit1,
    input  logic             parity0,
    input  logic             parity1,
    output logic             res_valid,
    output logic             res_parity,
    output logic             mismatch,
    output logic             proto_err,
    output logic             timeout,
    output logic [CNT_W-1:0] xfer_count
);

    localparam bit          TO_EN_C   = (TIMEOUT_CYCLES != 32'sd0);
    localparam logic [31:0] TO_LAST_C = 32'(TIMEOUT_CYCLES) - 32'd1;

    logic [RAIL_N-1:0] rx_rails_s;
    logic [RAIL_N-1:0] rx_sync_s;
    logic              p0_s;
    logic              p1_s;

    state_e            state_r,      state_s;
    logic [31:0]       wait_cnt_r,   wait_cnt_s;
    logic              bit0_r,       bit0_s;
    logic              bit1_r,       bit1_s;
    logic              in_ready_r,   in_ready_s;
    logic              res_valid_r,  res_valid_s;
    logic              res_parity_r, res_parity_s;
    logic              mismatch_r,   mismatch_s;
    logic              proto_err_r,  proto_err_s;
    logic              timeout_r,    timeout_s;
    logic [CNT_W-1:0]  xfer_count_r, xfer_count_s;
    logic              zeros_odd_r,  zeros_odd_s;
    logic              exp_even_r,   exp_even_s;
    logic              timeout_hit_s;

    assign rx_rails_s[RAIL_P0] = parity0;
    assign rx_rails_s[RAIL_P1] = parity1;

    rail_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_p0 (
        .clk (clk),
        .rst (rst),
        .d   (rx_rails_s[RAIL_P0]),
        .q   (rx_sync_s[RAIL_P0])
    );

    rail_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_p1 (
        .clk (clk),
        .rst (rst),
        .d   (rx_rails_s[RAIL_P1]),
        .q   (rx_sync_s[RAIL_P1])
    );

    assign p0_s = rx_sync_s[RAIL_P0];
    assign p1_s = rx_sync_s[RAIL_P1];

    // The wait counter restarts at 0 on entry, so the last count before expiry is TIMEOUT_CYCLES-1.
    assign timeout_hit_s = TO_EN_C && (wait_cnt_r == TO_LAST_C);

    // Next-state, handshake outputs, model update and counters.
    always_comb begin
        state_s      = state_r;
        bit0_s       = bit0_r;
        bit1_s       = bit1_r;
        res_valid_s  = 1'b0;
        res_parity_s = res_parity_r;
        mismatch_s   = mismatch_r;
        proto_err_s  = proto_err_r;
        timeout_s    = timeout_r;
        xfer_count_s = xfer_count_r;
        zeros_odd_s  = zeros_odd_r;
        exp_even_s   = exp_even_r;

        case (state_r)
            IDLE: begin
                if (p0_s | p1_s) begin
                    proto_err_s = 1'b1;
                    bit0_s      = 1'b0;
                    bit1_s      = 1'b0;
                    state_s     = FAULT;
                end else if (in_valid & in_ready_r) begin
                    bit1_s      = in_bit;
                    bit0_s      = ~in_bit;
                    zeros_odd_s = zeros_odd_next(zeros_odd_r, in_bit);
                    exp_even_s  = ~zeros_odd_next(zeros_odd_r, in_bit);
                    state_s     = DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                if (p0_s & p1_s) begin
                    proto_err_s = 1'b1;
                    bit0_s      = 1'b0;
                    bit1_s      = 1'b0;
                    state_s     = FAULT;
                end else if (p0_s | p1_s) begin
                    res_valid_s  = 1'b1;
                    res_parity_s = p1_s;
                    if (p1_s != exp_even_r) begin
                        mismatch_s = 1'b1;
                    end else begin
                        mismatch_s = mismatch_r;
                    end
                    bit0_s  = 1'b0;
                    bit1_s  = 1'b0;
                    state_s = RTZ;
                end else if (timeout_hit_s) begin
                    timeout_s = 1'b1;
                    bit0_s    = 1'b0;
                    bit1_s    = 1'b0;
                    state_s   = FAULT;
                end else begin
                    state_s = DRIVE;
                end
            end
            RTZ: begin
                if (p0_s & p1_s) begin
                    proto_err_s = 1'b1;
                    state_s     = FAULT;
                end else if (!p0_s & !p1_s) begin
                    xfer_count_s = xfer_count_r + CNT_W'(1'b1);
                    state_s      = IDLE;
                end else if (timeout_hit_s) begin
                    timeout_s = 1'b1;
                    state_s   = FAULT;
                end else begin
                    state_s = RTZ;
                end
            end
            FAULT: begin
                bit0_s  = 1'b0;
                bit1_s  = 1'b0;
                state_s = FAULT;
            end
            default: begin
                bit0_s  = 1'b0;
                bit1_s  = 1'b0;
                state_s = FAULT;
            end
        endcase

        in_ready_s = (state_s == IDLE);

        if (state_s != state_r) begin
            wait_cnt_s = 32'd0;
        end else if ((state_r == DRIVE) || (state_r == RTZ)) begin
            wait_cnt_s = wait_cnt_r + 32'd1;
        end else begin
            wait_cnt_s = 32'd0;
        end
    end

    // State, output and model registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            wait_cnt_r   <= 32'd0;
            bit0_r       <= 1'b0;
            bit1_r       <= 1'b0;
            in_ready_r   <= 1'b0;
            res_valid_r  <= 1'b0;
            res_parity_r <= 1'b0;
            mismatch_r   <= 1'b0;
            proto_err_r  <= 1'b0;
            timeout_r    <= 1'b0;
            xfer_count_r <= '0;
            zeros_odd_r  <= 1'b0;
            exp_even_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            wait_cnt_r   <= wait_cnt_s;
            bit0_r       <= bit0_s;
            bit1_r       <= bit1_s;
            in_ready_r   <= in_ready_s;
            res_valid_r  <= res_valid_s;
            res_parity_r <= res_parity_s;
            mismatch_r   <= mismatch_s;
            proto_err_r  <= proto_err_s;
            timeout_r    <= timeout_s;
            xfer_count_r <= xfer_count_s;
            zeros_odd_r  <= zeros_odd_s;
            exp_even_r   <= exp_even_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign bit0       = bit0_r;
    assign bit1       = bit1_r;
    assign res_valid  = res_valid_r;
    assign res_parity = res_parity_r;
    assign mismatch   = mismatch_r;
    assign proto_err  = proto_err_r;
    assign timeout    = timeout_r;
    assign xfer_count = xfer_count_r;

    evenzeroes_tx_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .bit0 (bit0_r),
        .bit1 (bit1_r)
    );

endmodule

// File: tb/tb_evenzeroes_tx.sv
// Self-checking bench for evenzeroes_tx with a behavioural dual-rail receiver.
module tb_evenzeroes_tx;

    localparam int RX_NORMAL      = 0;
    localparam int RX_SILENT      = 1;
    localparam int RX_BOTH        = 2;
    localparam int RX_WRONG_FIRST = 3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_bit;
    logic        in_ready;
    logic        bit0;
    logic        bit1;
    logic        parity0;
    logic        parity1;
    logic        res_valid;
    logic        res_parity;
    logic        mismatch;
    logic        proto_err;
    logic        timeout;
    logic [15:0] xfer_count;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int tb_zeros = 0;
    int rx_mode  = RX_NORMAL;
    int rx_zeros;
    bit rx_busy;
    bit rx_wrong_done = 1'b0;
    bit rx_even;

    evenzeroes_tx #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .in_ready   (in_ready),
        .bit0       (bit0),
        .bit1       (bit1),
        .parity0    (parity0),
        .parity1    (parity1),
        .res_valid  (res_valid),
        .res_parity (res_parity),
        .mismatch   (mismatch),
        .proto_err  (proto_err),
        .timeout    (timeout),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural receiver: counts zeros itself and answers on the parity rails.
    initial begin
        parity0 = 1'b0; parity1 = 1'b0; rx_zeros = 0; rx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                parity0 = 1'b0; parity1 = 1'b0; rx_zeros = 0; rx_busy = 1'b0;
            end else if (!rx_busy && (bit0 === 1'b1 || bit1 === 1'b1)) begin
                if (rx_mode == RX_SILENT) begin
                    rx_busy = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    rx_busy = 1'b0;
                end else if (rx_mode == RX_BOTH) begin
                    parity0 = 1'b1; parity1 = 1'b1; rx_busy = 1'b1;
                end else begin
                    if (bit0 === 1'b1) rx_zeros++;
                    rx_even = (rx_zeros % 2 == 0);
                    if (rx_mode == RX_WRONG_FIRST && !rx_wrong_done) begin
                        rx_even = !rx_even;
                        rx_wrong_done = 1'b1;
                    end
                    parity1 = rx_even; parity0 = !rx_even; rx_busy = 1'b1;
                end
            end else if (rx_busy && bit0 === 1'b0 && bit1 === 1'b0) begin
                if ($urandom_range(0, 2) != 0) begin
                    parity0 = 1'b0; parity1 = 1'b0; rx_busy = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; tb_zeros = 0; rx_wrong_done = 1'b0; rx_mode = RX_NORMAL;
        @(negedge clk);
    endtask

    // Offer one bit and hold it until the handshake edge; call at a negedge.
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        in_valid = 1'b1; in_bit = b;
        while (in_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            chk_cnt++;
            $display("FAIL send_wait: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic p);
        int n;
        n = 0; p = 1'bx;
        while (res_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            chk_cnt++;
            $display("FAIL res_wait: res_valid=%b, required 1", res_valid);
        end else begin
            p = res_parity;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            chk_cnt++;
            $display("FAIL idle_wait: in_ready=%b, required 1", in_ready);
        end
    endtask

    // Model: expected answer is whether the total number of zeros sent is even.
    function automatic logic model_push(input logic b);
        if (b == 1'b0) tb_zeros++;
        return (tb_zeros % 2 == 0);
    endfunction

    task automatic send_and_check(input logic b, input string name);
        logic p;
        logic e;
        e = model_push(b);
        send_bit(b);
        wait_result(p);
        chk_cnt++;
        if (p !== e) $display("FAIL %s: res_parity=%b, required %b (bit %b)", name, p, e, b);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({in_ready, bit0, bit1, res_valid, res_parity, mismatch, proto_err, timeout} !== 8'b0)
            $display("FAIL reset_outputs: got %b, required 00000000",
                     {in_ready, bit0, bit1, res_valid, res_parity, mismatch, proto_err, timeout});
        else pass_cnt++;
        chk_cnt++;
        if (xfer_count !== 16'd0) $display("FAIL reset_count: got %0d, required 0", xfer_count);
        else pass_cnt++;
        rst = 1'b0; tb_zeros = 0;
        @(negedge clk);
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        do_reset();
        bits = 4'b1001;
        for (int i = 3; i >= 0; i--) send_and_check(bits[i], "basic_parity");
        wait_idle();
        chk_cnt++;
        if (mismatch !== 1'b0) $display("FAIL basic_mismatch: got %b, required 0", mismatch);
        else pass_cnt++;
        chk_cnt++;
        if (xfer_count !== 16'd4) $display("FAIL basic_count: got %0d, required 4", xfer_count);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int n_bits;
        n_bits = 24;
        do_reset();
        for (int i = 0; i < n_bits; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_and_check(1'($urandom_range(0, 1)), "rand_parity");
        end
        wait_idle();
        chk_cnt++;
        if (xfer_count !== 16'(n_bits)) $display("FAIL rand_count: got %0d, required %0d", xfer_count, n_bits);
        else pass_cnt++;
        chk_cnt++;
        if ({mismatch, proto_err, timeout} !== 3'b000)
            $display("FAIL rand_flags: got %b, required 000", {mismatch, proto_err, timeout});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic exp_q[$];
        int   n_bits, z, idx, got, cyc;
        logic prev_ready, acc_pending;
        n_bits = 10;
        do_reset();
        z = 0;
        for (int i = 0; i < n_bits; i++) begin
            if (i % 2 == 1) z++;
            exp_q.push_back(z % 2 == 0);
        end
        idx = 0; got = 0; cyc = 0; prev_ready = 1'b0; acc_pending = 1'b0;
        in_valid = 1'b1; in_bit = 1'b1;
        while (got < n_bits && cyc < 3000) begin
            if (res_valid === 1'b1) begin
                chk_cnt++;
                if (res_parity !== exp_q[got])
                    $display("FAIL b2b_parity: result %0d res_parity=%b, required %b", got, res_parity, exp_q[got]);
                else pass_cnt++;
                got++;
            end
            if (in_valid && in_ready === 1'b1) begin
                chk_cnt++;
                if (prev_ready !== 1'b0) $display("FAIL b2b_ready_width: in_ready high two cycles running, required one");
                else pass_cnt++;
                acc_pending = 1'b1;
            end
            prev_ready = in_ready;
            @(negedge clk);
            cyc++;
            if (acc_pending) begin
                idx++; acc_pending = 1'b0;
                if (idx >= n_bits) in_valid = 1'b0;
                else in_bit = (idx % 2 == 0);
            end
        end
        chk_cnt++;
        if (got != n_bits || idx != n_bits)
            $display("FAIL b2b_totals: results %0d accepts %0d, required %0d each", got, idx, n_bits);
        else pass_cnt++;
        wait_idle();
        chk_cnt++;
        if (xfer_count !== 16'(n_bits)) $display("FAIL b2b_count: got %0d, required %0d", xfer_count, n_bits);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int k, n, hi;
        do_reset();
        rx_mode = RX_SILENT;
        in_valid = 1'b1; in_bit = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        k = 0;
        while (k < 40) begin
            @(posedge clk); k++;
            @(negedge clk);
            if (k == 1) begin
                chk_cnt++;
                if (bit1 !== 1'b1) $display("FAIL to_drive_rail: bit1=%b, required 1", bit1);
                else pass_cnt++;
            end
            if (timeout === 1'b1) break;
        end
        chk_cnt++;
        if (k != 16) $display("FAIL timeout_latency: %0d cycles, required 16", k);
        else pass_cnt++;
        chk_cnt++;
        if ({bit0, bit1} !== 2'b00) $display("FAIL timeout_rails: got %b, required 00", {bit0, bit1});
        else pass_cnt++;
        hi = 0;
        repeat (20) begin @(negedge clk); if (in_ready !== 1'b0) hi++; end
        chk_cnt++;
        if (hi != 0) $display("FAIL timeout_hold: in_ready high %0d cycles, required 0", hi);
        else pass_cnt++;
        chk_cnt++;
        if ({timeout, proto_err} !== 2'b10) $display("FAIL timeout_flags: got %b, required 10", {timeout, proto_err});
        else pass_cnt++;
        in_valid = 1'b0;
    endtask

    task automatic test_proto();
        int n, hi;
        do_reset();
        rx_mode = RX_BOTH;
        send_bit(1'b0);
        n = 0;
        while (proto_err !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk_cnt++;
        if (proto_err !== 1'b1) $display("FAIL proto_flag: got %b, required 1", proto_err);
        else pass_cnt++;
        chk_cnt++;
        if ({bit0, bit1, timeout} !== 3'b000) $display("FAIL proto_rails: got %b, required 000", {bit0, bit1, timeout});
        else pass_cnt++;
        in_valid = 1'b1; hi = 0;
        repeat (10) begin @(negedge clk); if (in_ready !== 1'b0) hi++; end
        in_valid = 1'b0;
        chk_cnt++;
        if (hi != 0 || xfer_count !== 16'd0)
            $display("FAIL proto_hold: ready cycles %0d count %0d, required 0 and 0", hi, xfer_count);
        else pass_cnt++;
    endtask

    task automatic test_mismatch();
        logic p;
        logic e;
        do_reset();
        rx_mode = RX_WRONG_FIRST;
        e = !model_push(1'b1);
        send_bit(1'b1);
        wait_result(p);
        chk_cnt++;
        if (p !== e) $display("FAIL mm_first_parity: got %b, required %b", p, e);
        else pass_cnt++;
        chk_cnt++;
        if (mismatch !== 1'b1) $display("FAIL mm_set: got %b, required 1", mismatch);
        else pass_cnt++;
        e = model_push(1'b0);
        send_bit(1'b0);
        wait_result(p);
        chk_cnt++;
        if (p !== e) $display("FAIL mm_second_parity: got %b, required %b", p, e);
        else pass_cnt++;
        wait_idle();
        chk_cnt++;
        if ({mismatch, proto_err, xfer_count} !== {1'b1, 1'b0, 16'd2})
            $display("FAIL mm_sticky: mismatch %b proto %b count %0d, required 1 0 2", mismatch, proto_err, xfer_count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) send_and_check(1'($urandom_range(0, 1)), "mid_pre_parity");
        wait_idle();
        rx_mode = RX_SILENT;
        send_bit(1'b0);
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (bit0 !== 1'b1) $display("FAIL mid_driving: bit0=%b, required 1", bit0);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({bit0, bit1, in_ready, xfer_count} !== 19'd0)
            $display("FAIL mid_reset: rails %b%b ready %b count %0d, required all 0", bit0, bit1, in_ready, xfer_count);
        else pass_cnt++;
        rst = 1'b0; tb_zeros = 0; rx_mode = RX_NORMAL;
        @(negedge clk);
        send_and_check(1'b1, "mid_post_parity");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_timeout();
        test_proto();
        test_mismatch();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
